// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, LSB slice first.
// Valid/ready on both sides; S/Cout/V hold from the last completed result.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             SUB,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   slice;
  logic             msb_cin;
  logic             last;
  logic [WIDTH-1:0] s_in;

  assign slice = {1'b0, a_q[DIGIT-1:0]}
               + {1'b0, b_q[DIGIT-1:0]}
               + {{DIGIT{1'b0}}, carry};

  // carry into the top bit of the slice; meaningful on the last slice
  assign msb_cin = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice[DIGIT-1];
  assign last    = (cnt == CW'(N - 1));
  assign s_in    = WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT);

  assign IN_READY  = (state == IDLE);
  assign OUT_VALID = (state == DONE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (IN_VALID)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (OUT_READY) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      Cout  <= 1'b0;
      V     <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && IN_VALID) begin
        a_q   <= A;
        b_q   <= SUB ? ~B : B;
        carry <= SUB | Cin;
        cnt   <= '0;
      end
      // result shifts in from the top so slice 0 lands at the LSB
      if (state == RUN) begin
        a_q   <= a_q >> DIGIT;
        b_q   <= b_q >> DIGIT;
        carry <= slice[DIGIT];
        cnt   <= cnt + CW'(1);
        S     <= (S >> DIGIT) | s_in;
        Cout  <= slice[DIGIT];
        V     <= msb_cin ^ slice[DIGIT];
      end
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: DIGIT=4, 1 and 16 side by side
// against an integer-arithmetic reference model.
module tb_digit_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [2:0]  in_ready;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready = 3'b111;
  logic [2:0]  cout_o;
  logic [2:0]  v_o;
  logic [15:0] s_o [3];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid),
    .IN_READY(in_ready[0]), .A(a), .B(b), .Cin(cin),
    .SUB(sub), .OUT_VALID(out_valid[0]),
    .OUT_READY(out_ready[0]), .S(s_o[0]),
    .Cout(cout_o[0]), .V(v_o[0])
  );

  digit_serial_adder #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid),
    .IN_READY(in_ready[1]), .A(a), .B(b), .Cin(cin),
    .SUB(sub), .OUT_VALID(out_valid[1]),
    .OUT_READY(out_ready[1]), .S(s_o[1]),
    .Cout(cout_o[1]), .V(v_o[1])
  );

  digit_serial_adder #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid),
    .IN_READY(in_ready[2]), .A(a), .B(b), .Cin(cin),
    .SUB(sub), .OUT_VALID(out_valid[2]),
    .OUT_READY(out_ready[2]), .S(s_o[2]),
    .Cout(cout_o[2]), .V(v_o[2])
  );

  function automatic int lat(input int i);
    return (i == 0) ? 4 : (i == 1) ? 16 : 1;
  endfunction

  // returns {V, Cout, S} from plain integer arithmetic
  function automatic logic [17:0] model(
    input logic [15:0] x,
    input logic [15:0] y,
    input logic        ci,
    input logic        sb
  );
    int          ua, ub, sa, sy, res, ss;
    logic [31:0] rv;
    logic        c, ov;
    ua = int'(x);
    ub = int'(y);
    sa = int'($signed(x));
    sy = int'($signed(y));
    if (sb) begin
      res = ua - ub;
      ss  = sa - sy;
      c   = (ua >= ub);
    end else begin
      res = ua + ub + int'(ci);
      ss  = sa + sy + int'(ci);
      c   = (res > 65535);
    end
    ov = (ss > 32767) || (ss < -32768);
    rv = res;
    return {ov, c, rv[15:0]};
  endfunction

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [2:0]  known = '0;
  logic [2:0]  busy = '0;
  logic [2:0]  acc_p = '0;
  logic [2:0]  rst_p = '0;
  logic [2:0]  hs_p = '0;
  int          cyc [3];
  logic [17:0] exp_r [3];
  logic [17:0] held [3];
  logic [17:0] pend_m [3];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_p[i]) begin
        known[i] = 1'b1;
        busy[i]  = 1'b0;
        held[i]  = '0;
      end else if (acc_p[i]) begin
        busy[i]  = 1'b1;
        cyc[i]   = 0;
        exp_r[i] = pend_m[i];
      end else if (hs_p[i]) begin
        busy[i] = 1'b0;
        held[i] = exp_r[i];
      end else if (busy[i]) begin
        cyc[i]++;
      end
      if (known[i]) begin
        if (!busy[i]) begin
          check($sformatf("idle_ready%0d", i), 32'(in_ready[i]), 32'd1);
          check($sformatf("idle_valid%0d", i), 32'(out_valid[i]), 32'd0);
          check($sformatf("idle_hold%0d", i),
                32'({v_o[i], cout_o[i], s_o[i]}), 32'(held[i]));
        end else if (cyc[i] < lat(i)) begin
          check($sformatf("run_ready%0d", i), 32'(in_ready[i]), 32'd0);
          check($sformatf("run_valid%0d", i), 32'(out_valid[i]), 32'd0);
        end else begin
          check($sformatf("done_ready%0d", i), 32'(in_ready[i]), 32'd0);
          check($sformatf("done_valid%0d", i), 32'(out_valid[i]), 32'd1);
          check($sformatf("done_result%0d", i),
                32'({v_o[i], cout_o[i], s_o[i]}), 32'(exp_r[i]));
        end
      end
      rst_p[i] = !rst_n;
      acc_p[i] = rst_n && known[i] && !busy[i] && in_valid;
      hs_p[i]  = rst_n && busy[i] && (cyc[i] >= lat(i)) && out_ready[i];
      if (acc_p[i]) pend_m[i] = model(a, b, cin, sub);
    end
  end

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        ci;
    logic        sb;
    logic [15:0] s;
    logic        c;
    logic        v;
  } vec_t;

  vec_t vecs [6] = '{
    '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0},
    '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
    '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
    '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0},
    '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0},
    '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1}
  };

  task automatic wait_idle();
    int n = 0;
    while (in_ready !== 3'b111 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_wait", 32'(in_ready), 32'd7);
  endtask

  task automatic run_op(
    input logic [15:0] x,
    input logic [15:0] y,
    input logic        ci,
    input logic        sb
  );
    wait_idle();
    a = x;
    b = y;
    cin = ci;
    sub = sb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~x;
    b = y ^ 16'h5A5A;
    cin = ~ci;
    sub = ~sb;
  endtask

  initial begin
    int n;
    foreach (vecs[k])
      check($sformatf("model_pin%0d", k),
            32'(model(vecs[k].x, vecs[k].y, vecs[k].ci, vecs[k].sb)),
            32'({vecs[k].v, vecs[k].c, vecs[k].s}));

    repeat (2) @(posedge clk);
    #1;
    check("rst_s", 32'(s_o[0]), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd7);
    rst_n = 1'b1;

    foreach (vecs[k])
      run_op(vecs[k].x, vecs[k].y, vecs[k].ci, vecs[k].sb);
    wait_idle();
    check("hold_last_s", 32'(s_o[0]), 32'h7FFF);

    out_ready[0] = 1'b0;
    run_op(16'h1234, 16'h0FF0, 1'b0, 1'b0);
    n = 0;
    while (!out_valid[0] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp_valid", 32'(out_valid[0]), 32'd1);
    repeat (3) begin
      @(posedge clk);
      #1;
      a = a + 16'h1111;
      check("bp_ready_low", 32'(in_ready[0]), 32'd0);
      check("bp_s", 32'(s_o[0]), 32'h2224);
    end
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    check("bp_ready_next", 32'(in_ready[0]), 32'd1);

    run_op(16'hABCD, 16'h1111, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_ready", 32'(in_ready[0]), 32'd1);
    check("abort_valid", 32'(out_valid[0]), 32'd0);
    check("abort_s", 32'(s_o[0]), 32'd0);

    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
    wait_idle();
    check("after_abort_s", 32'(s_o[0]), 32'h0100);
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/digit_serial_adder.md
DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, operand and result width in bits.
REQ-002 SHALL provide parameter DIGIT, default 4, bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT, and 1 <= DIGIT <= WIDTH.
REQ-003 SHALL provide port CLK  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL provide port RST_N  input  1  reset, synchronous, active-low.
REQ-005 SHALL provide port IN_VALID  input  1  operand set offered.
REQ-006 SHALL provide port IN_READY  output  1  block can accept operands.
REQ-007 SHALL provide port A  input  WIDTH  operand A.
REQ-008 SHALL provide port B  input  WIDTH  operand B.
REQ-009 SHALL provide port Cin  input  1  carry-in; used only when SUB=0.
REQ-010 SHALL provide port SUB  input  1  mode: 0 = A+B+Cin, 1 = A-B.
REQ-011 SHALL provide port OUT_VALID  output  1  result available.
REQ-012 SHALL provide port OUT_READY  input  1  consumer takes result.
REQ-013 SHALL provide port S  output  WIDTH  sum/difference.
REQ-014 SHALL provide port Cout  output  1  carry-out of MSB; for SUB=1, 1 = no borrow.
REQ-015 SHALL provide port V  output  1  two's-complement signed overflow.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; IN_READY = 1 only in IDLE, OUT_VALID = 1 only in DONE.
REQ-017 SHALL accept operands on an edge where state=IDLE and IN_VALID=1: latch A, B (B inverted if SUB=1), carry (Cin if SUB=0, 1 if SUB=1), clear the digit counter, and go to RUN.
REQ-018 SHALL ignore A, B, Cin, SUB and IN_VALID while in RUN or DONE.
REQ-019 SHALL in RUN add one DIGIT-bit slice per edge, LSB slice first, propagating a registered carry between slices; N = WIDTH/DIGIT slices.
REQ-020 SHALL leave RUN for DONE on the edge processing slice N-1; OUT_VALID SHALL first be high exactly N cycles after the accept edge.
REQ-021 SHALL hold S, Cout and V stable throughout DONE until the handshake completes.
REQ-022 SHALL complete output handshake on an edge with state=DONE and OUT_READY=1, returning to IDLE; IN_READY is high in the following cycle. No overlap of accept and result phases.
REQ-023 SHALL compute S = (A + B' + c0) mod 2^WIDTH, Cout = bit WIDTH of that sum, V = carry into MSB XOR carry out of MSB.
REQ-024 SHALL produce identical results for DIGIT=1 (N=WIDTH) and DIGIT=WIDTH (N=1, OUT_VALID one cycle after accept).
REQ-025 SHALL keep S, Cout and V unchanged in IDLE from the last completed result; they are updated only during RUN.

Reset
REQ-026 SHALL on an edge with RST_N=0 force state to IDLE and clear S, Cout, V, the carry register and the digit counter, regardless of the current state, including mid-RUN.
REQ-027 SHALL after reset drive IN_READY=1, OUT_VALID=0, S=0, Cout=0, V=0; no partial result from an aborted operation is ever presented.

Verification (WIDTH=16, DIGIT=4, N=4)
REQ-028 SHALL check that A=0x00FF, B=0x0001, Cin=0, SUB=0 -> S=0x0100, Cout=0, V=0, OUT_VALID high exactly 4 cycles after accept.
REQ-029 SHALL check carry/overflow: 0xFFFF+0x0001 -> S=0x0000, Cout=1, V=0; 0x7FFF+0x0001 -> S=0x8000, Cout=0, V=1; 0xFFFF+0xFFFF with Cin=1 -> S=0xFFFF, Cout=1.
REQ-030 SHALL check subtract: A=0x0005, B=0x0007, SUB=1, Cin=1 -> S=0xFFFE, Cout=0, V=0 (Cin ignored); 0x8000-0x0001 -> S=0x7FFF, V=1, Cout=1.
REQ-031 SHALL check backpressure: OUT_READY low 3 cycles in DONE -> S/Cout/V/OUT_VALID stable, IN_READY=0, and A changed during RUN/DONE has no effect; OUT_READY high -> IN_READY=1 next cycle.
REQ-032 SHALL check reset: RST_N=0 during the 2nd RUN cycle -> next cycle IN_READY=1, OUT_VALID=0, S=0; a subsequent operation completes correctly.
REQ-033 SHALL repeat the scenarios in REQ-028 and REQ-029 with DIGIT=1 (latency 16) and DIGIT=16 (latency 1), expecting identical S/Cout/V.
